// File: rtl/snake_pkg.sv
// Shared types for the snake game: heading encoding, scheduler states and
// helpers used by both the step scheduler and the datapath.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_REQ  = 2'd2
    } state_t;

    // Opposite pairs differ only in bit 0: UP/DOWN and LEFT/RIGHT.
    function automatic dir_t opposite(input dir_t d);
        return {d[1], ~d[0]};
    endfunction

    // Step period in cycles: max(floor, base - sz*dec), never below 1.
    // The underflow case is caught before the subtraction is taken.
    function automatic logic [31:0] step_period(input logic [31:0] base,
                                                input logic [31:0] dec,
                                                input logic [31:0] floor_p,
                                                input logic [4:0]  sz);
        logic [31:0] cut;
        logic [31:0] p;
        cut = dec * {27'd0, sz};
        if (cut >= base) begin
            p = floor_p;
        end else begin
            p = base - cut;
        end
        if (p < floor_p) begin
            p = floor_p;
        end
        if (p == 32'd0) begin
            p = 32'd1;
        end
        return p;
    endfunction

endpackage

// File: rtl/snake_dir_filter.sv
// Pending-heading register: picks the winning key of the cycle and drops it
// when it would reverse the snake onto itself.
module snake_dir_filter
    import snake_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       key_up_i,
    input  logic       key_down_i,
    input  logic       key_left_i,
    input  logic       key_right_i,
    input  logic [1:0] committed_i,
    output logic [1:0] pend_o,
    output logic [1:0] next_o
);

    dir_t pend_q;
    dir_t pend_d;
    dir_t key_dir_d;
    logic key_any_d;
    logic accept_d;

    always_comb begin
        key_any_d = key_up_i | key_down_i | key_left_i | key_right_i;
        key_dir_d = DIR_RIGHT;
        if (key_up_i) begin
            key_dir_d = DIR_UP;
        end else if (key_down_i) begin
            key_dir_d = DIR_DOWN;
        end else if (key_left_i) begin
            key_dir_d = DIR_LEFT;
        end
        // Only the priority winner is tested against the committed heading.
        accept_d = key_any_d && (key_dir_d != opposite(committed_i));
        pend_d   = accept_d ? key_dir_d : pend_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= DIR_RIGHT;
        end else if (clear_i) begin
            pend_q <= DIR_RIGHT;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;
    // Includes this cycle's key so a press on the latch edge is not lost.
    assign next_o = pend_d;

endmodule

// File: rtl/snake_step_scheduler.sv
// Paces snake movement: one step request per move period, carrying the
// committed heading, with a shrinking period and a handshake timeout.
module snake_step_scheduler
    import snake_pkg::*;
#(
    parameter int unsigned BASE_PERIOD  = 25_000_000,
    parameter int unsigned PERIOD_DEC   = 1_000_000,
    parameter int unsigned MIN_PERIOD   = 5_000_000,
    parameter int unsigned DONE_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gamePrepare,
    input  logic        gameStart,
    input  logic        gameEnd,
    input  logic [4:0]  size,
    input  logic        Up,
    input  logic        Down,
    input  logic        Left,
    input  logic        Right,
    input  logic        step_done,
    output logic        step_req,
    output logic [1:0]  step_dir,
    output logic [15:0] step_cnt,
    output logic        step_err,
    output logic [1:0]  dbg_state,
    output logic [1:0]  dbg_pend_dir
);

    // Handshake: step_req rises with step_dir valid and holds both until
    // step_done is seen high on a clock edge while in REQ; that edge drops
    // step_req. step_done outside REQ is ignored. No step_done within
    // DONE_TIMEOUT REQ cycles abandons the step and sets sticky step_err.

    localparam logic [31:0] TMO_LAST = 32'(DONE_TIMEOUT - 1);

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [31:0] tmo_q;
    logic        step_req_q;
    dir_t        step_dir_q;
    logic [15:0] step_cnt_q;
    logic        step_err_q;

    logic [31:0] period_d;
    logic        play_d;
    logic [1:0]  next_dir_d;
    logic [1:0]  pend_dir_d;

    snake_dir_filter u_dir_filter (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (gamePrepare),
        .key_up_i    (Up),
        .key_down_i  (Down),
        .key_left_i  (Left),
        .key_right_i (Right),
        .committed_i (step_dir_q),
        .pend_o      (pend_dir_d),
        .next_o      (next_dir_d)
    );

    assign period_d = step_period(BASE_PERIOD, PERIOD_DEC, MIN_PERIOD, size);
    assign play_d   = gameStart & ~gameEnd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            step_req_q <= 1'b0;
            step_dir_q <= DIR_RIGHT;
            step_cnt_q <= '0;
            step_err_q <= 1'b0;
        end else if (gamePrepare) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            step_req_q <= 1'b0;
            step_dir_q <= DIR_RIGHT;
            step_cnt_q <= '0;
            step_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (play_d) begin
                        state_q <= ST_RUN;
                        cnt_q   <= period_d - 32'd1;
                    end
                end
                ST_RUN: begin
                    if (!play_d) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == 32'd0) begin
                        state_q    <= ST_REQ;
                        step_req_q <= 1'b1;
                        step_dir_q <= next_dir_d;
                        tmo_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                ST_REQ: begin
                    // A step already requested is completed even if play ends.
                    if (step_done) begin
                        step_req_q <= 1'b0;
                        step_cnt_q <= step_cnt_q + 16'd1;
                        if (play_d) begin
                            state_q <= ST_RUN;
                            cnt_q   <= period_d - 32'd1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        step_req_q <= 1'b0;
                        step_err_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    step_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign step_req     = step_req_q;
    assign step_dir     = step_dir_q;
    assign step_cnt     = step_cnt_q;
    assign step_err     = step_err_q;
    assign dbg_state    = state_q;
    assign dbg_pend_dir = pend_dir_d;

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Bench for snake_step_scheduler: table of period/heading vectors, directed
// handshake, timeout and reset sequences, then randomized steps vs a model.
module tb_snake_step_scheduler;

    localparam int BASE = 20;
    localparam int DEC  = 4;
    localparam int MINP = 6;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        gamePrepare;
    logic        gameStart;
    logic        gameEnd;
    logic [4:0]  size;
    logic        Up;
    logic        Down;
    logic        Left;
    logic        Right;
    logic        step_done;
    logic        step_req;
    logic [1:0]  step_dir;
    logic [15:0] step_cnt;
    logic        step_err;
    logic [1:0]  dbg_state;
    logic [1:0]  dbg_pend_dir;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int         sz;
        logic [3:0] keys;      // {Up, Down, Left, Right}
        int         key_at;
        int         exp_p;
        logic [1:0] exp_dir;
    } vec_t;

    vec_t vecs[6];

    // Reference model state for the randomized phase.
    logic [1:0] m_pend;
    logic [1:0] m_comm;
    logic [15:0] m_cnt;
    logic [1:0] exp_q[$];
    int opp_tab[4] = '{1, 0, 3, 2};

    snake_step_scheduler #(
        .BASE_PERIOD (BASE),
        .PERIOD_DEC  (DEC),
        .MIN_PERIOD  (MINP),
        .DONE_TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .gamePrepare (gamePrepare),
        .gameStart   (gameStart),
        .gameEnd     (gameEnd),
        .size        (size),
        .Up          (Up),
        .Down        (Down),
        .Left        (Left),
        .Right       (Right),
        .step_done   (step_done),
        .step_req    (step_req),
        .step_dir    (step_dir),
        .step_cnt    (step_cnt),
        .step_err    (step_err),
        .dbg_state   (dbg_state),
        .dbg_pend_dir(dbg_pend_dir)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Driver and checker tasks.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_prepare();
        gamePrepare = 1'b1;
        tick();
        gamePrepare = 1'b0;
    endtask

    // Ticks until step_req is seen high; t is the tick count, -1 on timeout.
    task automatic run_until_req(input int limit, input int key_at, input logic [3:0] keys,
                                 output int t);
        t = -1;
        for (int i = 1; i <= limit; i++) begin
            if (i == key_at) {Up, Down, Left, Right} = keys;
            tick();
            {Up, Down, Left, Right} = 4'b0000;
            if (step_req) begin
                t = i;
                break;
            end
        end
    endtask

    function automatic int ref_period(input int sz);
        int p;
        p = BASE - DEC * sz;
        if (p < MINP) p = MINP;
        return p;
    endfunction

    function automatic void model_key(input logic [3:0] k);
        int w;
        w = -1;
        if (k[3]) w = 0;
        else if (k[2]) w = 1;
        else if (k[1]) w = 2;
        else if (k[0]) w = 3;
        if (w >= 0 && w != opp_tab[m_comm]) m_pend = 2'(w);
    endfunction

    task automatic rand_tick();
        logic [3:0] k;
        for (int b = 0; b < 4; b++) k[b] = ($urandom_range(0, 5) == 0);
        {Up, Down, Left, Right} = k;
        tick();
        {Up, Down, Left, Right} = 4'b0000;
        model_key(k);
    endtask

    initial begin
        int t;
        int r1;
        int kk;
        int seen;
        int p;
        int d;

        rst = 1'b0; gamePrepare = 1'b0; gameStart = 1'b0; gameEnd = 1'b0;
        size = '0; {Up, Down, Left, Right} = 4'b0000; step_done = 1'b0;

        vecs[0] = '{0,  4'b0000, 1,  20, 2'd3};
        vecs[1] = '{5,  4'b0010, 2,  6,  2'd3};
        vecs[2] = '{31, 4'b1001, 1,  6,  2'd0};
        vecs[3] = '{3,  4'b0100, 8,  8,  2'd1};
        vecs[4] = '{1,  4'b0011, 3,  16, 2'd3};
        vecs[5] = '{2,  4'b0110, 12, 12, 2'd1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", step_req, 0);
        check("rst_dir", step_dir, 3);
        check("rst_cnt", step_cnt, 0);
        check("rst_err", step_err, 0);
        rst = 1'b1;
        tick();

        // Basic pacing: first rise, one-cycle wait then done, then immediate done.
        do_prepare();
        size = 5'd0; gameStart = 1'b1;
        tick();
        run_until_req(60, 0, 4'b0000, t);
        check("first_rise", t, 20);
        check("first_dir", step_dir, 3);
        check("first_cnt", step_cnt, 0);
        r1 = cyc;
        tick();
        check("req_held", step_req, 1);
        step_done = 1'b1; tick(); step_done = 1'b0;
        check("cnt_1", step_cnt, 1);
        check("req_drop_1", step_req, 0);
        run_until_req(60, 0, 4'b0000, t);
        check("gap_wait1", cyc - r1, 22);
        r1 = cyc;
        step_done = 1'b1; tick(); step_done = 1'b0;
        check("cnt_2", step_cnt, 2);
        run_until_req(60, 0, 4'b0000, t);
        check("gap_min", cyc - r1, 21);
        step_done = 1'b1; gameStart = 1'b0; tick(); step_done = 1'b0;
        tick();

        // Table of period/heading vectors, each from a fresh prepare.
        for (int v = 0; v < 6; v++) begin
            do_prepare();
            check($sformatf("tbl%0d_cnt0", v), step_cnt, 0);
            size = 5'(vecs[v].sz);
            gameStart = 1'b1;
            tick();
            run_until_req(60, vecs[v].key_at, vecs[v].keys, t);
            check($sformatf("tbl%0d_period", v), t, vecs[v].exp_p);
            check($sformatf("tbl%0d_dir", v), step_dir, vecs[v].exp_dir);
            step_done = 1'b1; gameStart = 1'b0; tick(); step_done = 1'b0;
            tick();
        end

        // Keys: Left ignored, Up+Right gives UP, Down on latch edge ignored.
        do_prepare();
        size = 5'd3; gameStart = 1'b1;
        tick();
        {Up, Down, Left, Right} = 4'b0010; tick(); {Up, Down, Left, Right} = 4'b0000;
        run_until_req(60, 3, 4'b1001, t);
        check("key_rise", t, 7);
        check("key_up", step_dir, 0);
        step_done = 1'b1; tick(); step_done = 1'b0;
        run_until_req(60, 8, 4'b0100, t);
        check("key_rise2", t, 8);
        check("key_down_ign", step_dir, 0);

        // gameEnd during REQ: request held, then done retires it to IDLE.
        gameEnd = 1'b1;
        repeat (5) tick();
        check("end_req_held", step_req, 1);
        check("end_dir_held", step_dir, 0);
        step_done = 1'b1; tick(); step_done = 1'b0;
        check("end_req_drop", step_req, 0);
        check("end_cnt", step_cnt, 2);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step_done = (i == 5);
            tick();
            if (step_req) seen++;
        end
        step_done = 1'b0;
        check("end_idle_noreq", seen, 0);
        check("end_done_ign", step_cnt, 2);
        gameEnd = 1'b0;
        run_until_req(60, 0, 4'b0000, t);
        check("end_restart", t, 9);
        step_done = 1'b1; gameStart = 1'b0; tick(); step_done = 1'b0;

        // Timeout after one completed step.
        do_prepare();
        size = 5'd3; gameStart = 1'b1;
        tick();
        run_until_req(60, 0, 4'b0000, t);
        step_done = 1'b1; tick(); step_done = 1'b0;
        run_until_req(60, 0, 4'b0000, t);
        check("tmo_rise", t, 8);
        kk = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (!step_req) begin
                kk = k;
                break;
            end
        end
        gameStart = 1'b0;
        check("tmo_len", kk, TMO);
        check("tmo_err", step_err, 1);
        check("tmo_cnt", step_cnt, 1);
        repeat (3) tick();
        check("tmo_err_sticky", step_err, 1);
        check("tmo_req_low", step_req, 0);
        do_prepare();
        check("prep_err_clr", step_err, 0);
        check("prep_cnt_clr", step_cnt, 0);

        // Async reset mid-RUN and mid-REQ.
        size = 5'd3; gameStart = 1'b1;
        tick();
        run_until_req(60, 2, 4'b1000, t);
        check("ar_dir_up", step_dir, 0);
        step_done = 1'b1; tick(); step_done = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        check("ar_run_req", step_req, 0);
        check("ar_run_dir", step_dir, 3);
        check("ar_run_cnt", step_cnt, 0);
        check("ar_run_err", step_err, 0);
        gameStart = 1'b0;
        rst = 1'b1;
        tick();
        gameStart = 1'b1;
        run_until_req(60, 2, 4'b1000, t);
        check("ar_rise", t, 9);
        check("ar_req_dir", step_dir, 0);
        #2 rst = 1'b0;
        #1;
        check("ar_req_req", step_req, 0);
        check("ar_req_dir_rst", step_dir, 3);
        gameStart = 1'b0;
        rst = 1'b1;
        tick();

        // Randomized steps against the reference model.
        do_prepare();
        m_pend = 2'd3; m_comm = 2'd3; m_cnt = '0;
        size = 5'($urandom_range(0, 31));
        gameStart = 1'b1;
        tick();
        p = ref_period(int'(size));
        for (int s = 0; s < 12; s++) begin
            for (int i = 1; i <= p; i++) begin
                rand_tick();
                if (i == p - 1) check("rnd_early", step_req, 0);
                if (i == p) begin
                    m_comm = m_pend;
                    exp_q.push_back(m_pend);
                end
            end
            check("rnd_req", step_req, 1);
            check("rnd_dir", step_dir, exp_q.pop_front());
            check("rnd_pend", dbg_pend_dir, m_pend);
            check("rnd_cnt", step_cnt, m_cnt);
            d = $urandom_range(0, 3);
            size = 5'($urandom_range(0, 31));
            for (int j = 0; j < d; j++) rand_tick();
            check("rnd_hold", step_req, 1);
            step_done = 1'b1;
            rand_tick();
            step_done = 1'b0;
            m_cnt = m_cnt + 16'd1;
            check("rnd_drop", step_req, 0);
            check("rnd_cnt_inc", step_cnt, m_cnt);
            p = ref_period(int'(size));
        end
        gameStart = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
